// File: rtl/div_top_core_if.sv
// Operand/result bundle for div_top_core. With DIV_TOP_DBZ_FLAG_EN defined the
// bundle also carries the divide-by-zero flag dbz.
interface div_top_core_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
`ifdef DIV_TOP_DBZ_FLAG_EN
  logic             dbz;

  modport master (output in_valid, a, b, input out_valid, q, r, dbz);
  modport slave  (input in_valid, a, b, output out_valid, q, r, dbz);
`else
  modport master (output in_valid, a, b, input out_valid, q, r);
  modport slave  (input in_valid, a, b, output out_valid, q, r);
`endif
endinterface

// File: rtl/div_top_core.sv
// Pipelined restoring unsigned divider, one quotient bit per stage, MSB first.
// Optional DIV_TOP_DBZ_FLAG_EN adds a pipelined divide-by-zero flag (bus.dbz).
module div_top_core #(
  parameter int WIDTH = 6
) (
  input logic         clk,
  input logic         rst,
  div_top_core_if.slave bus
);

  // Stored remainders are always below 2^WIDTH; the guard bit lives in the trial.
  // dq holds unconsumed dividend bits at the top and resolved quotient bits below.
  logic [WIDTH-1:0] vld_r;
  logic [WIDTH-1:0] rem_r [WIDTH];
  logic [WIDTH-1:0] dq_r  [WIDTH];
  logic [WIDTH-1:0] div_r [WIDTH-1];

  logic [WIDTH-1:0] src_rem_s [WIDTH];
  logic [WIDTH-1:0] src_dq_s  [WIDTH];
  logic [WIDTH-1:0] src_div_s [WIDTH];
  logic [WIDTH-1:0] nxt_rem_s [WIDTH];
  logic [WIDTH-1:0] nxt_dq_s  [WIDTH];

  logic             out_valid_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;

`ifdef DIV_TOP_DBZ_FLAG_EN
  logic [WIDTH-1:0] zf_r;
  logic             dbz_r;
`endif

  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] dq,
    input logic [WIDTH-1:0] div
  );
    logic [WIDTH:0] trial_s;
    trial_s = {rem, dq[WIDTH-1]};
    // A successful trial leaves a difference below div, so WIDTH-bit subtraction is exact.
    if (trial_s >= {1'b0, div}) begin
      return {trial_s[WIDTH-1:0] - div, dq[WIDTH-2:0], 1'b1};
    end else begin
      return {trial_s[WIDTH-1:0], dq[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Stage inputs and next-state values for every stage.
  always_comb begin
    src_rem_s[0] = '0;
    src_dq_s[0]  = bus.a;
    src_div_s[0] = bus.b;
    for (int s = 1; s < WIDTH; s++) begin
      src_rem_s[s] = rem_r[s-1];
      src_dq_s[s]  = dq_r[s-1];
      src_div_s[s] = div_r[s-1];
    end
    for (int s = 0; s < WIDTH; s++) begin
      {nxt_rem_s[s], nxt_dq_s[s]} = div_step(src_rem_s[s], src_dq_s[s], src_div_s[s]);
    end
  end

  // Pipeline stage registers; a bubble only clears the stage valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      for (int s = 0; s < WIDTH; s++) begin
        rem_r[s] <= '0;
        dq_r[s]  <= '0;
      end
      for (int s = 0; s < WIDTH-1; s++) begin
        div_r[s] <= '0;
      end
`ifdef DIV_TOP_DBZ_FLAG_EN
      zf_r <= '0;
`endif
    end else begin
      vld_r <= {vld_r[WIDTH-2:0], bus.in_valid};
      for (int s = 0; s < WIDTH; s++) begin
        rem_r[s] <= nxt_rem_s[s];
        dq_r[s]  <= nxt_dq_s[s];
      end
      for (int s = 0; s < WIDTH-1; s++) begin
        div_r[s] <= src_div_s[s];
      end
`ifdef DIV_TOP_DBZ_FLAG_EN
      zf_r <= {zf_r[WIDTH-2:0], (bus.b == '0)};
`endif
    end
  end

  // Output register: results update only on a valid pulse and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
`ifdef DIV_TOP_DBZ_FLAG_EN
      dbz_r       <= 1'b0;
`endif
    end else begin
      out_valid_r <= vld_r[WIDTH-1];
      if (vld_r[WIDTH-1]) begin
        q_r   <= dq_r[WIDTH-1];
        r_r   <= rem_r[WIDTH-1];
`ifdef DIV_TOP_DBZ_FLAG_EN
        dbz_r <= zf_r[WIDTH-1];
`endif
      end else begin
        q_r   <= q_r;
        r_r   <= r_r;
`ifdef DIV_TOP_DBZ_FLAG_EN
        dbz_r <= dbz_r;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.r         = r_r;
`ifdef DIV_TOP_DBZ_FLAG_EN
  assign bus.dbz       = dbz_r;
`endif

endmodule

// File: tb/tb_div_top_core.sv
// Self-checking bench for div_top_core (WIDTH=6): directed and random operands
// compared each cycle against a timestamped queue of arithmetic results.
module tb_div_top_core;

  localparam int W = 6;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   cyc;

  typedef struct {
    int           due;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_z;

  div_top_core_if #(.WIDTH(W)) bus ();

  div_top_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // Results come straight from integer division, with the b==0 encoding.
  task automatic push_ref(input int av, input int bv);
    exp_t e;
    e.due = cyc + W;
    e.z   = (bv == 0);
    if (bv == 0) begin
      e.q = W'((1 << W) - 1);
      e.r = W'(av);
    end else begin
      e.q = W'(av / bv);
      e.r = W'(av % bv);
    end
    exp_q.push_back(e);
  endtask

  task automatic check_outputs();
    logic ev;
    ev = 1'b0;
    if (exp_q.size() > 0) begin
      if (exp_q[0].due == cyc) begin
        ev     = 1'b1;
        last_q = exp_q[0].q;
        last_r = exp_q[0].r;
        last_z = exp_q[0].z;
        void'(exp_q.pop_front());
      end
    end
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("q", 32'(bus.q), 32'(last_q));
    chk("r", 32'(bus.r), 32'(last_r));
`ifdef DIV_TOP_DBZ_FLAG_EN
    chk("dbz", 32'(bus.dbz), 32'(last_z));
`endif
  endtask

  task automatic step(input logic v, input int av, input int bv, input logic rs);
    bus.in_valid = v;
    bus.a        = W'(av);
    bus.b        = W'(bv);
    rst          = rs;
    @(posedge clk);
    cyc++;
    if (rs) begin
      exp_q.delete();
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end else if (v) begin
      push_ref(av, bv);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    cyc          = 0;
    last_q       = '0;
    last_r       = '0;
    last_z       = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    // Reset for two cycles.
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 5, 3, 1'b1);

    // Single operation 13/4, then idle through its latency.
    step(1'b1, 13, 4, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 0, 0, 1'b0);
    chk("ex13_4_q", 32'(bus.q), 32'd3);
    chk("ex13_4_r", 32'(bus.r), 32'd1);
    step(1'b0, 0, 0, 1'b0);

    // Back-to-back stream with boundary operands.
    step(1'b1, 31, 31, 1'b0);
    step(1'b1, 5, 7, 1'b0);
    step(1'b1, 63, 1, 1'b0);
    step(1'b1, 0, 9, 1'b0);
    for (int i = 0; i < W + 2; i++) step(1'b0, 0, 0, 1'b0);

    // Divide by zero.
    step(1'b1, 9, 0, 1'b0);
    for (int i = 0; i < W + 1; i++) step(1'b0, 0, 0, 1'b0);
    chk("dbz_q", 32'(bus.q), 32'd63);
    chk("dbz_r", 32'(bus.r), 32'd9);

    // Exhaustive sweep with in_valid held high.
    for (int av = 0; av < 64; av++) begin
      for (int bv = 1; bv < 64; bv++) step(1'b1, av, bv, 1'b0);
    end
    for (int i = 0; i < W + 1; i++) step(1'b0, 0, 0, 1'b0);

    // Random operands with random bubbles, b==0 included.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 63)), 1'b0);
    end
    for (int i = 0; i < W + 1; i++) step(1'b0, 0, 0, 1'b0);

    // Static operands held valid give stable q/r.
    for (int i = 0; i < W + 4; i++) step(1'b1, 50, 7, 1'b0);
    chk("static_q", 32'(bus.q), 32'd7);
    chk("static_r", 32'(bus.r), 32'd1);

    // Flush: three ops in flight, reset two cycles later.
    step(1'b1, 40, 3, 1'b0);
    step(1'b1, 41, 5, 1'b0);
    step(1'b1, 42, 0, 1'b0);
    step(1'b1, 60, 2, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < W + 3; i++) step(1'b0, 0, 0, 1'b0);
    chk("flush_q", 32'(bus.q), 32'd0);
    chk("flush_r", 32'(bus.r), 32'd0);
    chk("flush_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
